// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int DEF_GAP_CYCLES     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 100000;
  localparam int DEF_TMO_W          = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  winner
);

  logic [ID_W:0] sum_s;
  logic [ID_W:0] idx_s;

  // Scan offsets from highest to lowest so the smallest offset from ptr is the last write.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    sum_s  = '0;
    idx_s  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum_s  = {1'b0, ptr} + (ID_W + 1)'(i);
      idx_s  = (sum_s >= (ID_W + 1)'(N_REQ)) ? (sum_s - (ID_W + 1)'(N_REQ)) : sum_s;
      winner = req[idx_s[ID_W-1:0]] ? idx_s[ID_W-1:0] : winner;
      valid  = valid | req[idx_s[ID_W-1:0]];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between N_REQ requesters.
// Holds Tx_En_Sig for exactly one frame, enforces an idle gap, aborts hung frames.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TMO_W          = DEF_TMO_W,
  localparam int ID_W          = $clog2(N_REQ)
) (
  input  logic                         CLOCK_50M,
  input  logic                         RST_n,
  input  logic [N_REQ-1:0]             Req_Sig,
  input  logic [UART_DATA_W*N_REQ-1:0] Req_Data,
  output logic [N_REQ-1:0]             Ack_Sig,
  output logic [N_REQ-1:0]             Done_Sig,
  output logic                         Err_Sig,
  output logic                         Busy_Sig,
  output logic [ID_W-1:0]              Grant_Id,
  output logic                         Tx_En_Sig,
  output logic [UART_DATA_W-1:0]       Tx_Data,
  input  logic                         Tx_Done_Sig
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [N_REQ-1:0] ONE_HOT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

  state_e                 state_q,    state_d;
  logic [ID_W-1:0]        rr_ptr_q,   rr_ptr_d;
  logic [TMO_W-1:0]       tmo_cnt_q,  tmo_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q,  gap_cnt_d;
  logic                   tx_en_q,    tx_en_d;
  logic [UART_DATA_W-1:0] tx_data_q,  tx_data_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [N_REQ-1:0]       ack_q,      ack_d;
  logic [N_REQ-1:0]       done_q,     done_d;
  logic                   err_q,      err_d;
  logic                   busy_q,     busy_d;

  logic                   pick_valid_s;
  logic [ID_W-1:0]        pick_win_s;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (Req_Sig),
    .ptr    (rr_ptr_q),
    .valid  (pick_valid_s),
    .winner (pick_win_s)
  );

  // Next-state logic: grant in IDLE, watch done/timeout in SEND, count down the gap.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    tmo_cnt_d  = tmo_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tx_en_d    = tx_en_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    ack_d      = '0;
    done_d     = '0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          tx_data_d  = Req_Data[UART_DATA_W*pick_win_s +: UART_DATA_W];
          grant_id_d = pick_win_s;
          ack_d      = ONE_HOT_LSB << pick_win_s;
          tx_en_d    = 1'b1;
          rr_ptr_d   = (pick_win_s == ID_W'(N_REQ - 1)) ? '0 : (pick_win_s + ID_W'(1));
          tmo_cnt_d  = '0;
          state_d    = ST_SEND;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_SEND: begin
        // A done pulse on the final watchdog cycle still counts as a clean frame.
        if (Tx_Done_Sig) begin
          tx_en_d   = 1'b0;
          done_d    = ONE_HOT_LSB << grant_id_q;
          gap_cnt_d = GAP_W'(GAP_CYCLES);
          state_d   = ST_GAP;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tx_en_d   = 1'b0;
          err_d     = 1'b1;
          gap_cnt_d = GAP_W'(GAP_CYCLES);
          state_d   = ST_GAP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: begin
        tx_en_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and all registered outputs; async reset clears everything.
  always_ff @(posedge CLOCK_50M or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      tmo_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      tmo_cnt_q  <= tmo_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign Ack_Sig   = ack_q;
  assign Done_Sig  = done_q;
  assign Err_Sig   = err_q;
  assign Busy_Sig  = busy_q;
  assign Grant_Id  = grant_id_q;
  assign Tx_En_Sig = tx_en_q;
  assign Tx_Data   = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (GAP_CYCLES=4, TIMEOUT_CYCLES=200).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_sig;
  logic [31:0] req_data;
  logic [3:0]  ack_sig;
  logic [3:0]  done_sig;
  logic        err_sig;
  logic        busy_sig;
  logic [1:0]  grant_id;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_done;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(
    .N_REQ          (4),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (200),
    .TMO_W          (17)
  ) dut (
    .CLOCK_50M   (clk),
    .RST_n       (rst_n),
    .Req_Sig     (req_sig),
    .Req_Data    (req_data),
    .Ack_Sig     (ack_sig),
    .Done_Sig    (done_sig),
    .Err_Sig     (err_sig),
    .Busy_Sig    (busy_sig),
    .Grant_Id    (grant_id),
    .Tx_En_Sig   (tx_en),
    .Tx_Data     (tx_data),
    .Tx_Done_Sig (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on the negedge right after the grant edge; ends on the negedge after done.
  task automatic run_frame(input string tag, input int w, input logic [7:0] b,
                           input logic [3:0] req_after);
    logic [3:0] oh;
    bit ok;
    oh = 4'b0001 << w;
    check_eq({tag, "_ack"},   {28'd0, ack_sig}, {28'd0, oh});
    check_eq({tag, "_grant"}, {30'd0, grant_id}, w);
    check_eq({tag, "_data"},  {24'd0, tx_data}, {24'd0, b});
    check_eq({tag, "_en"},    {31'd0, tx_en}, 32'd1);
    req_sig = req_after;
    ok = 1'b1;
    for (int i = 1; i < 50; i++) begin
      @(negedge clk);
      ok = ok && (tx_en === 1'b1) && (tx_data === b) && (ack_sig === 4'b0000)
              && (done_sig === 4'b0000);
    end
    check_eq({tag, "_hold"}, {31'd0, ok}, 32'd1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check_eq({tag, "_done"},    {28'd0, done_sig}, {28'd0, oh});
    check_eq({tag, "_en_low"},  {31'd0, tx_en}, 32'd0);
    check_eq({tag, "_no_err"},  {31'd0, err_sig}, 32'd0);
    check_eq({tag, "_busy"},    {31'd0, busy_sig}, 32'd1);
  endtask

  initial begin
    bit ok;
    rst_n    = 1'b0;
    req_sig  = 4'b0000;
    req_data = 32'd0;
    tx_done  = 1'b0;

    // Reset state
    wait_cycles(2);
    check_eq("rst_en",    {31'd0, tx_en}, 32'd0);
    check_eq("rst_data",  {24'd0, tx_data}, 32'd0);
    check_eq("rst_ack",   {28'd0, ack_sig}, 32'd0);
    check_eq("rst_done",  {28'd0, done_sig}, 32'd0);
    check_eq("rst_err",   {31'd0, err_sig}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy_sig}, 32'd0);
    check_eq("rst_grant", {30'd0, grant_id}, 32'd0);
    rst_n = 1'b1;

    // 1. Single request
    req_sig  = 4'b0001;
    req_data = 32'h0000_00A5;
    wait_cycles(1);
    run_frame("t1", 0, 8'hA5, 4'b0000);
    wait_cycles(3);
    check_eq("t1_gap_busy", {31'd0, busy_sig}, 32'd1);
    wait_cycles(1);
    check_eq("t1_idle_busy",   {31'd0, busy_sig}, 32'd0);
    check_eq("t1_data_retain", {24'd0, tx_data}, 32'h0000_00A5);
    check_eq("t1_done_clear",  {28'd0, done_sig}, 32'd0);

    // 2. Fairness from a fresh pointer
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    req_sig  = 4'b1111;
    req_data = 32'h4433_2211;
    wait_cycles(1);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] exp_b;
      exp_b = 8'h11 * 8'((k % 4) + 1);
      run_frame($sformatf("t2_%0d", k), k % 4, exp_b, (k < 4) ? 4'b1111 : 4'b0000);
      wait_cycles(2);
      check_eq($sformatf("t2_%0d_gap_noack", k), {28'd0, ack_sig}, 32'd0);
      if (k < 4) begin
        wait_cycles(3);
      end else begin
        wait_cycles(2);
        check_eq("t2_idle_busy", {31'd0, busy_sig}, 32'd0);
      end
    end

    // 3. Rotation after partial grant: pointer at 1 -> grant 2, then 0101 wraps to 0
    req_sig = 4'b0100;
    wait_cycles(1);
    run_frame("t3a", 2, 8'h33, 4'b0101);
    wait_cycles(5);
    run_frame("t3b", 0, 8'h11, 4'b0000);
    wait_cycles(4);
    check_eq("t3_idle_busy", {31'd0, busy_sig}, 32'd0);

    // 4. Timeout: pointer at 1, requester 1 never gets a done
    req_sig = 4'b0010;
    wait_cycles(1);
    check_eq("t4_ack", {28'd0, ack_sig}, 32'h2);
    req_sig = 4'b0000;
    ok = 1'b1;
    for (int i = 1; i < 200; i++) begin
      @(negedge clk);
      ok = ok && (tx_en === 1'b1) && (err_sig === 1'b0);
    end
    check_eq("t4_en_held", {31'd0, ok}, 32'd1);
    wait_cycles(1);
    check_eq("t4_err",     {31'd0, err_sig}, 32'd1);
    check_eq("t4_en_low",  {31'd0, tx_en}, 32'd0);
    check_eq("t4_no_done", {28'd0, done_sig}, 32'd0);
    check_eq("t4_busy",    {31'd0, busy_sig}, 32'd1);
    req_sig = 4'b1000;
    wait_cycles(1);
    check_eq("t4_err_pulse", {31'd0, err_sig}, 32'd0);
    wait_cycles(3);
    check_eq("t4_gap_noack", {28'd0, ack_sig}, 32'd0);
    wait_cycles(1);
    run_frame("t4b", 3, 8'h44, 4'b0000);
    wait_cycles(4);

    // 5. Done on the timeout cycle wins; stray done pulses ignored
    req_sig = 4'b0001;
    wait_cycles(1);
    check_eq("t5_ack", {28'd0, ack_sig}, 32'h1);
    req_sig = 4'b0000;
    wait_cycles(199);
    tx_done = 1'b1;
    wait_cycles(1);
    tx_done = 1'b0;
    check_eq("t5_done",   {28'd0, done_sig}, 32'h1);
    check_eq("t5_no_err", {31'd0, err_sig}, 32'd0);
    check_eq("t5_en_low", {31'd0, tx_en}, 32'd0);
    wait_cycles(1);
    check_eq("t5_no_err_late", {31'd0, err_sig}, 32'd0);
    tx_done = 1'b1;
    wait_cycles(1);
    tx_done = 1'b0;
    check_eq("t5_gap_stray_done", {28'd0, done_sig}, 32'd0);
    check_eq("t5_gap_stray_en",   {31'd0, tx_en}, 32'd0);
    check_eq("t5_gap_stray_busy", {31'd0, busy_sig}, 32'd1);
    wait_cycles(2);
    check_eq("t5_idle_busy", {31'd0, busy_sig}, 32'd0);
    tx_done = 1'b1;
    wait_cycles(1);
    tx_done = 1'b0;
    check_eq("t5_idle_stray_done", {28'd0, done_sig}, 32'd0);
    check_eq("t5_idle_stray_en",   {31'd0, tx_en}, 32'd0);
    check_eq("t5_idle_stray_busy", {31'd0, busy_sig}, 32'd0);
    check_eq("t5_data_retain",     {24'd0, tx_data}, 32'h11);
    check_eq("t5_grant_retain",    {30'd0, grant_id}, 32'd0);

    // 6. Reset mid-SEND, then pointer restarts at 0
    req_sig = 4'b0100;
    wait_cycles(1);
    check_eq("t6_grant", {30'd0, grant_id}, 32'd2);
    req_sig = 4'b0000;
    wait_cycles(20);
    check_eq("t6_en_before", {31'd0, tx_en}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_en",    {31'd0, tx_en}, 32'd0);
    check_eq("t6_rst_busy",  {31'd0, busy_sig}, 32'd0);
    check_eq("t6_rst_data",  {24'd0, tx_data}, 32'd0);
    check_eq("t6_rst_grant", {30'd0, grant_id}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    req_sig = 4'b1000;
    wait_cycles(1);
    run_frame("t6b", 3, 8'h44, 4'b0000);
    wait_cycles(4);
    check_eq("t6_idle_busy", {31'd0, busy_sig}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
